// File: rtl/pipe_rr_sched.sv
// Round-robin scheduler sharing one LAT-cycle add/sub-multiply pipeline among NREQ requesters.
// Define PIPE_RR_SCHED_STATS_EN to add per-requester saturating issue counters and stat ports.
module pipe_rr_sched #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned LAT  = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      en,
    input  logic [NREQ-1:0]           req,
    input  logic [8*NREQ-1:0]         op_a,
    input  logic [8*NREQ-1:0]         op_b,
    input  logic [8*NREQ-1:0]         op_c,
    input  logic [NREQ-1:0]           op_s,
    output logic [NREQ-1:0]           gnt,
    output logic [7:0]                pipe_a,
    output logic [7:0]                pipe_b,
    output logic [7:0]                pipe_c,
    output logic                      pipe_s,
    input  logic [15:0]               pipe_d,
    output logic [NREQ-1:0]           rsp_valid,
    output logic [15:0]               rsp_data,
`ifdef PIPE_RR_SCHED_STATS_EN
    input  logic [$clog2(NREQ)-1:0]   stat_sel,
    output logic [15:0]               stat_cnt,
`endif
    output logic                      idle
);
    localparam int unsigned IW = $clog2(NREQ);

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    state_e         r_state;
    logic [IW-1:0]  r_ptr;
    logic [LAT-1:0] r_vld;
    logic [IW-1:0]  r_idx [LAT];

    logic           w_issue_ok;
    logic           w_win_vld;
    logic [IW-1:0]  w_win_idx;
    logic           w_rem;

    assign w_issue_ok = (r_state == StRun) && en;

    // Search starts just past the last winner so every requester gets a turn.
    always_comb begin : arb
        logic [IW-1:0] v_j;
        w_win_vld = 1'b0;
        w_win_idx = '0;
        v_j       = '0;
        for (int k = 1; k <= int'(NREQ); k++) begin
            v_j = IW'((int'(r_ptr) + k) % int'(NREQ));
            if (w_issue_ok && !w_win_vld && req[v_j]) begin
                w_win_vld = 1'b1;
                w_win_idx = v_j;
            end
        end
    end

    always_comb begin
        gnt    = '0;
        pipe_a = '0;
        pipe_b = '0;
        pipe_c = '0;
        pipe_s = 1'b0;
        if (w_win_vld) begin
            gnt[w_win_idx] = 1'b1;
            pipe_a         = op_a[8*w_win_idx +: 8];
            pipe_b         = op_b[8*w_win_idx +: 8];
            pipe_c         = op_c[8*w_win_idx +: 8];
            pipe_s         = op_s[w_win_idx];
        end
    end

    always_comb begin
        rsp_valid = '0;
        if (r_vld[LAT-1]) begin
            rsp_valid[r_idx[LAT-1]] = 1'b1;
        end
    end

    assign rsp_data = pipe_d;

    // Anything still in flight after this edge, ignoring the stage that retires now.
    always_comb begin
        w_rem = 1'b0;
        for (int i = 0; i < int'(LAT) - 1; i++) begin
            w_rem = w_rem | r_vld[i];
        end
    end

    assign idle = (r_state == StIdle) && (r_vld == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= StIdle;
            r_ptr   <= IW'(NREQ - 1);
            r_vld   <= '0;
            for (int i = 0; i < int'(LAT); i++) begin
                r_idx[i] <= '0;
            end
        end else begin
            case (r_state)
                StIdle:  if (en) r_state <= StRun;
                StRun:   if (!en) r_state <= StDrain;
                StDrain: begin
                    if (en) begin
                        r_state <= StRun;
                    end else if (!w_rem) begin
                        r_state <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
            if (w_win_vld) begin
                r_ptr <= w_win_idx;
            end
            r_vld[0] <= w_win_vld;
            r_idx[0] <= w_win_idx;
            for (int i = 1; i < int'(LAT); i++) begin
                r_vld[i] <= r_vld[i-1];
                r_idx[i] <= r_idx[i-1];
            end
        end
    end

`ifdef PIPE_RR_SCHED_STATS_EN
    logic [15:0] r_cnt [NREQ];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(NREQ); i++) begin
                r_cnt[i] <= '0;
            end
        end else if (w_win_vld && (r_cnt[w_win_idx] != 16'hFFFF)) begin
            r_cnt[w_win_idx] <= r_cnt[w_win_idx] + 16'd1;
        end
    end

    assign stat_cnt = r_cnt[stat_sel];
`endif

endmodule

// File: doc/pipe_rr_sched.md
Name: pipe_rr_sched

Overview:
- Round-robin scheduler that shares one two-stage add/sub-then-multiply pipeline among NREQ requesters.
- Each cycle it grants at most one requester and muxes that requester's operands onto the pipeline inputs.
- It tracks the requester tag through the fixed 2-cycle pipeline latency and steers each result back to its owner.
- It sits between the requesting engines and the pipeline instance, and adds enable/drain control so software can quiesce the pipeline.

Parameters:
- NREQ, 4, number of requesters (2..8).
- LAT, 2, pipeline latency in cycles from operand capture edge to valid d.

Ports:
- clk  input  1  rising-edge clock for all state.
- reset  input  1  asynchronous, active-low reset (assert low clears all state immediately).
- en  input  1  scheduler enable; 0 = stop issuing and drain.
- req  input  NREQ  per-requester request, level; held with operands until granted.
- op_a  input  8*NREQ  packed a operands; requester i at [8i+7:8i].
- op_b  input  8*NREQ  packed b operands.
- op_c  input  8*NREQ  packed c operands.
- op_s  input  NREQ  per-requester add(1)/sub(0) select.
- gnt  output  NREQ  one-hot grant, combinational, valid in issue cycle.
- pipe_a  output  8  operand a to pipeline.
- pipe_b  output  8  operand b to pipeline.
- pipe_c  output  8  operand c to pipeline.
- pipe_s  output  1  add/sub select to pipeline.
- pipe_d  input  16  pipeline result.
- rsp_valid  output  NREQ  one-hot result strobe, one cycle.
- rsp_data  output  16  result, equals pipe_d when any rsp_valid is high.
- idle  output  1  state IDLE and nothing in flight.

Behaviour:
- Reset values: gnt=0, rsp_valid=0, idle=1, tag/valid shift register cleared, state=IDLE, rr pointer=NREQ-1 (so req[0] has highest priority first).
- While reset is low, pipe_a, pipe_b, pipe_c and pipe_s drive 0.
- rsp_data passes pipe_d through unconditionally and is don't-care when rsp_valid=0.
- State machine:
  - IDLE: no issue. Goes to RUN when en=1.
  - RUN: issue allowed. Goes to DRAIN when en=0.
  - DRAIN: no issue. Goes to IDLE when in-flight count is 0; goes to RUN if en returns to 1 first.
- Arbitration, RUN only:
  - Search req starting at pointer+1, wrapping modulo NREQ; the first set bit wins.
  - gnt goes high for the winner in the same cycle.
  - pipe_* are muxed from the winner's operands; when there is no winner they hold 0.
  - On the following clock edge, pointer becomes the winner index; the pointer is unchanged when there is no grant.
- Handshake:
  - A requester sees gnt[i]=1 in cycle T, and its operands are consumed at the end of T.
  - It may drop req or present new operands in T+1; re-granting it requires winning arbitration again.
  - A single requester that keeps req high is granted every cycle (full throughput).
- Tag pipeline:
  - LAT-deep shift of {valid, index}; the issue cycle T loads stage 0.
  - rsp_valid[index] is high in cycle T+LAT, concurrently with pipe_d holding that issue's result.
  - In-flight count is the number of valid stages.
- Simultaneous events:
  - en falling in a cycle with requests: no grant that cycle (gnt is gated by state==RUN and en==1).
  - Issue and retire in the same cycle: both happen; the count is unchanged.
- Reset mid-operation: in-flight tags are discarded and no rsp_valid is produced for them; the pipeline instance is reset by the same system reset.
- idle=1 only in IDLE with count 0; it rises the cycle after the last rsp_valid.
- Width rules: operands are forwarded unmodified; the arithmetic belongs to the pipeline.

Optional Feature:
- Macro: PIPE_RR_SCHED_STATS_EN.
- Defined:
  - Adds one 16-bit saturating issue counter per requester, incremented on each gnt and holding at 16'hFFFF.
  - Adds ports stat_sel (input, clog2(NREQ)) and stat_cnt (output, 16), where stat_cnt = counter[stat_sel] combinationally.
  - Counters clear on reset.
- Undefined: no counters and no stat ports; behaviour is otherwise identical.

Test Plan:
- Single request: req=4'b0010, a=5, b=3, c=2, s=1 at T.
  - Required: gnt=4'b0010 at T; pipe_a=5 at T; rsp_valid=4'b0010 at T+2 with rsp_data=16 (behavioural pipeline model).
- All four requesting from reset, each held until granted.
  - Required: grants in order 0,1,2,3 on consecutive cycles; rsp_valid one-hot sequence 1,2,4,8 starting 2 cycles later.
- Back-to-back same requester: req[2] held for 5 cycles with changing operands.
  - Required: 5 consecutive grants; 5 rsp_valid[2] pulses; data matches each operand set in order.
- Drain: drop en one cycle after issuing two ops.
  - Required: no further gnt; both responses delivered; idle rises one cycle after the second rsp_valid.
  - Then re-raise en: state returns to RUN and grants resume.
- Reset mid-flight: pull reset low at T+1 after an issue at T.
  - Required: rsp_valid stays 0 through T+3; gnt=0; idle=1; after release, req[0] wins first.
- With PIPE_RR_SCHED_STATS_EN: 3 grants to requester 1, then stat_sel=1.
  - Required: stat_cnt=3; stat_sel=0 reads 0.
